// File: rtl/pcm_audio_pkg.sv
// pcm_audio_pkg: state encoding and frame constants shared by the PCM audio
// transmit and capture blocks.
package pcm_audio_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_MCLK_DIV = 2;
  function automatic int frame_len(input int sample_w);
    return 2 * sample_w;
  endfunction
endpackage

// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo: synchronous FIFO with push/pop, full/empty flags, async reset.
module pcm_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      if (do_push != do_pop) cnt_q <= do_push ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
endmodule

// File: rtl/pcm_audio_tx.sv
// pcm_audio_tx: FIFO-buffered left-justified serial PCM transmitter with own mclk/ws.
// PCM_AUDIO_TX_STEREO_DUP_EN: right slot repeats the left sample instead of zeros.
module pcm_audio_tx
  import pcm_audio_pkg::*;
#(
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int MCLK_DIV   = DEF_MCLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                mclk,
  output logic                ws,
  output logic                dataout,
  output logic                done,
  output logic                underrun
);
  localparam int FW = frame_len(SAMPLE_W);
  localparam int DW = $clog2(MCLK_DIV + 1);
  localparam int BW = $clog2(FW);
  state_e              state_q;
  logic [FW-1:0]       sr_q;
  logic [DW-1:0]       div_q;
  logic [BW-1:0]       bit_q;
  logic                mclk_q, ws_q, done_q, underrun_q;
  logic [SAMPLE_W-1:0] fifo_data, left, right;
  logic                fifo_full, fifo_empty, wrap, fall, last, load;
  assign wrap = div_q == DW'(MCLK_DIV - 1);
  assign fall = state_q == RUN && wrap && mclk_q;
  assign last = fall && bit_q == BW'(FW - 1);
  // a frame load happens either on leaving IDLE or gaplessly on the last falling edge
  assign load = enable && (state_q == IDLE || last);
  assign left = fifo_empty ? '0 : fifo_data;
`ifdef PCM_AUDIO_TX_STEREO_DUP_EN
  assign right = left;
`else
  assign right = '0;
`endif
  assign sample_ready = !fifo_full;
  assign mclk         = mclk_q;
  assign ws           = ws_q;
  assign dataout      = sr_q[FW-1];
  assign done         = done_q;
  assign underrun     = underrun_q;
  pcm_sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (sample_valid),
    .pop   (load),
    .wdata (sample_in),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      mclk_q     <= 1'b0;
      ws_q       <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= last;
      underrun_q <= load && fifo_empty;
      if (load || last) begin
        state_q <= load ? RUN : IDLE;
        sr_q    <= load ? {left, right} : '0;
        div_q   <= '0;
        bit_q   <= '0;
        mclk_q  <= 1'b0;
        ws_q    <= 1'b0;
      end else if (state_q == RUN) begin
        div_q <= wrap ? '0 : div_q + 1'b1;
        if (wrap) mclk_q <= !mclk_q;
        if (fall) begin
          bit_q <= bit_q + 1'b1;
          sr_q  <= sr_q << 1;
          ws_q  <= bit_q >= BW'(SAMPLE_W - 1);
        end
      end
    end
endmodule

// File: tb/tb_pcm_audio_tx.sv
// tb_pcm_audio_tx: directed scenario tests for pcm_audio_tx at default parameters.
module tb_pcm_audio_tx;
`ifdef PCM_AUDIO_TX_STEREO_DUP_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, mclk, ws, dataout, done, underrun;
  int          n_checks = 0;
  int          n_fail = 0;

  pcm_audio_tx dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mclk         (mclk),
    .ws           (ws),
    .dataout      (dataout),
    .done         (done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_frame(input logic [15:0] s);
    return {s, DUP ? s : 16'h0000};
  endfunction

  // Records dataout/ws on each mclk rise and the cycle done first appears, bounded.
  task automatic capture(output logic [31:0] bits, output logic [31:0] wsv, output int done_at);
    int n = 0;
    logic pm = mclk;
    bits = '0;
    wsv = '0;
    done_at = -1;
    for (int c = 1; c <= 200 && done_at < 0; c++) begin
      @(posedge clk); #1;
      if (mclk && !pm && n < 32) begin
        bits[31-n] = dataout;
        wsv[31-n] = ws;
        n++;
      end
      pm = mclk;
      if (done) done_at = c;
    end
  endtask

  task automatic push_one(input logic [15:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    n_checks++;
    if ({mclk, ws, dataout, done, underrun, sample_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_in: got %b expected 000001", {mclk, ws, dataout, done, underrun, sample_ready});
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mclk, ws, dataout, done, underrun, sample_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected 000001", {mclk, ws, dataout, done, underrun, sample_ready});
    end
  endtask

  task automatic test_frame;
    logic [31:0] bits, wsv;
    int d;
    push_one(16'hA5C3);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    n_checks++;
    if ({dataout, ws, mclk, underrun} !== 4'b1000) begin
      n_fail++;
      $display("FAIL frame_load: got %b expected 1000", {dataout, ws, mclk, underrun});
    end
    capture(bits, wsv, d);
    n_checks++;
    if (bits !== exp_frame(16'hA5C3)) begin
      n_fail++;
      $display("FAIL frame_bits: got %h expected %h", bits, exp_frame(16'hA5C3));
    end
    n_checks++;
    if (wsv !== 32'h0000FFFF) begin
      n_fail++;
      $display("FAIL frame_ws: got %h expected 0000ffff", wsv);
    end
    n_checks++;
    if (d !== 128) begin
      n_fail++;
      $display("FAIL frame_done: got %0d expected 128", d);
    end
    n_checks++;
    if ({mclk, ws, dataout} !== 3'b000) begin
      n_fail++;
      $display("FAIL frame_idle: got %b expected 000", {mclk, ws, dataout});
    end
  endtask

  task automatic test_underrun;
    logic [31:0] bits, wsv;
    int d;
    enable = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({underrun, dataout} !== 2'b10) begin
      n_fail++;
      $display("FAIL underrun_load: got %b expected 10", {underrun, dataout});
    end
    push_one(16'h8001);
    capture(bits, wsv, d);
    n_checks++;
    if (bits !== 32'h0 || d !== 127) begin
      n_fail++;
      $display("FAIL underrun_frame: got %h/%0d expected 00000000/127", bits, d);
    end
    n_checks++;
    if ({dataout, underrun, ws, mclk} !== 4'b1000) begin
      n_fail++;
      $display("FAIL gapless_load: got %b expected 1000", {dataout, underrun, ws, mclk});
    end
    enable = 1'b0;
    capture(bits, wsv, d);
    n_checks++;
    if (bits !== exp_frame(16'h8001) || d !== 128) begin
      n_fail++;
      $display("FAIL gapless_frame: got %h/%0d expected %h/128", bits, d, exp_frame(16'h8001));
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] v [5] = '{16'hF00F, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEAD};
    logic [4:0] rdy;
    logic [31:0] bits, wsv;
    int d;
    for (int i = 0; i < 5; i++) begin
      sample_in = v[i];
      sample_valid = 1'b1;
      @(posedge clk); #1;
      rdy[i] = sample_ready;
    end
    sample_valid = 1'b0;
    n_checks++;
    if (rdy !== 5'b00111) begin
      n_fail++;
      $display("FAIL ready_fill: got %b expected 00111", rdy);
    end
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    n_checks++;
    if ({sample_ready, dataout} !== 2'b11) begin
      n_fail++;
      $display("FAIL ready_after_pop: got %b expected 11", {sample_ready, dataout});
    end
    capture(bits, wsv, d);
    n_checks++;
    if (bits !== exp_frame(16'hF00F) || d !== 128) begin
      n_fail++;
      $display("FAIL fifo_head_frame: got %h/%0d expected %h/128", bits, d, exp_frame(16'hF00F));
    end
  endtask

  task automatic test_enable_drop;
    logic [31:0] bits, wsv;
    int d;
    enable = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({dataout, underrun} !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_load: got %b expected 00", {dataout, underrun});
    end
    fork
      begin
        repeat (21) @(posedge clk);
        #1 enable = 1'b0;
      end
      capture(bits, wsv, d);
    join
    n_checks++;
    if (bits !== exp_frame(16'h1234) || d !== 128) begin
      n_fail++;
      $display("FAIL drop_frame: got %h/%0d expected %h/128", bits, d, exp_frame(16'h1234));
    end
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if ({mclk, ws, dataout, done, underrun} !== 5'b00000) begin
      n_fail++;
      $display("FAIL drop_idle: got %b expected 00000", {mclk, ws, dataout, done, underrun});
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] bits, wsv;
    int d;
    enable = 1'b1;
    @(posedge clk);
    repeat (82) @(posedge clk);
    #1;
    n_checks++;
    if ({ws, mclk} !== 2'b11) begin
      n_fail++;
      $display("FAIL bit20_state: got %b expected 11", {ws, mclk});
    end
    reset = 1'b1;
    enable = 1'b0;
    #1;
    n_checks++;
    if ({mclk, ws, dataout, sample_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 0001", {mclk, ws, dataout, sample_ready});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    n_checks++;
    if ({underrun, dataout} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_underrun: got %b expected 10", {underrun, dataout});
    end
    capture(bits, wsv, d);
    n_checks++;
    if (bits !== 32'h0 || d !== 128) begin
      n_fail++;
      $display("FAIL post_reset_frame: got %h/%0d expected 00000000/128", bits, d);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_underrun;
    test_back_to_back;
    test_enable_drop;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
